fetch_stage: RTL and testbench

//   Instruction-fetch stage: owns the PC register, drives the instruction ROM address, and captures the

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 24 ++
 rtl/fetch_stage.sv | 74 +++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, FSM state and IF/ID payload type for the fetch stage.
package fetch_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
    localparam logic [31:0] ROM_BASE  = 32'hBFC0_0000;
    localparam int unsigned ROM_BYTES = 4096;

    typedef enum logic {RUN, HALT} fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        fault;
    } if_id_t;

    localparam int IF_ID_W = $bits(if_id_t);
    localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc: '0, pc4: '0, fault: 1'b0};
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; squash beats load, neither means hold.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_squash,
    input  logic [IF_ID_W-1:0] i_d,
    output logic [IF_ID_W-1:0] o_q
);
    logic [IF_ID_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= IF_ID_BUBBLE;
        else if (i_squash)
            r_q <= IF_ID_BUBBLE;
        else if (i_load)
            r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection, fetch-fault check, RUN/HALT control and fetch counter.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int          ADDRESS_WIDTH = 32,
    parameter int          DATA_WIDTH    = 32,
    parameter logic [31:0] RESET_PC      = fetch_pkg::RESET_PC,
    parameter logic [31:0] ROM_BASE      = fetch_pkg::ROM_BASE,
    parameter int unsigned ROM_BYTES     = fetch_pkg::ROM_BYTES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0]    imem_instr_i,
    input  logic                     stall_i,
    input  logic                     redirect_i,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target_i,
    output logic                     if_id_valid_o,
    output logic [DATA_WIDTH-1:0]    if_id_instr_o,
    output logic [ADDRESS_WIDTH-1:0] if_id_pc_o,
    output logic [ADDRESS_WIDTH-1:0] if_id_pc4_o,
    output logic                     if_id_fault_o,
    output logic [31:0]              fetch_count_o
);
    // One extra bit so the window end cannot overflow for a window touching the top of memory.
    localparam logic [ADDRESS_WIDTH:0] ROM_END = {1'b0, ROM_BASE} + (ADDRESS_WIDTH + 1)'(ROM_BYTES);

    logic [ADDRESS_WIDTH-1:0] r_pc;
    fetch_state_t             r_state;
    logic [31:0]              r_count;
    logic [ADDRESS_WIDTH-1:0] w_pc4;
    logic                     w_fault;
    logic                     w_advance;
    if_id_t                   w_d;
    if_id_t                   w_q;

    assign w_pc4     = r_pc + ADDRESS_WIDTH'(4);
    assign w_fault   = (r_pc[1:0] != 2'b00) || (r_pc < ROM_BASE) || ({1'b0, r_pc} >= ROM_END);
    assign w_advance = !redirect_i && !stall_i && (r_state == RUN);
    assign w_d       = '{valid: 1'b1, instr: w_fault ? NOP_INSTR : imem_instr_i, pc: r_pc, pc4: w_pc4, fault: w_fault};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_state <= RUN;
            r_count <= '0;
        end else if (redirect_i) begin
            r_pc    <= redirect_target_i;
            r_state <= RUN;
        end else if (w_advance) begin
            r_count <= r_count + 32'd1;
            r_pc    <= w_fault ? r_pc : w_pc4;
            r_state <= w_fault ? HALT : RUN;
        end
    end

    // HALT keeps feeding bubbles downstream until a redirect restarts fetch.
    if_id_reg u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_advance),
        .i_squash (redirect_i || (!stall_i && r_state == HALT)),
        .i_d      (w_d),
        .o_q      (w_q)
    );

    assign imem_addr_o   = r_pc;
    assign if_id_valid_o = w_q.valid;
    assign if_id_instr_o = w_q.instr;
    assign if_id_pc_o    = w_q.pc;
    assign if_id_pc4_o   = w_q.pc4;
    assign if_id_fault_o = w_q.fault;
    assign fetch_count_o = r_count;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized stall/redirect traffic against a behavioural model.
module tb_fetch_stage;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam longint      BASE = 64'hBFC0_0000;
    localparam longint      TOP  = 64'hBFC0_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_instr, target, if_id_instr, if_id_pc, if_id_pc4, fetch_count;
    logic        stall = 1'b0, redirect = 1'b0, if_id_valid, if_id_fault;
    logic [31:0] rom [0:1023];
    int          errors = 0, checks = 0;

    // Behavioural model state: architectural PC, halted flag, IF/ID contents and fetch count.
    logic [31:0] m_pc, m_instr, m_ipc, m_pc4, m_cnt;
    logic        m_halt, m_valid, m_fault;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
        .stall_i(stall), .redirect_i(redirect), .redirect_target_i(target),
        .if_id_valid_o(if_id_valid), .if_id_instr_o(if_id_instr), .if_id_pc_o(if_id_pc),
        .if_id_pc4_o(if_id_pc4), .if_id_fault_o(if_id_fault), .fetch_count_o(fetch_count)
    );

    always #5 clk = ~clk;
    assign imem_instr = rom[imem_addr[11:2]];

    function automatic logic [31:0] rom_at(input logic [31:0] a);
        return rom[(a >> 2) & 32'd1023];
    endfunction

    function automatic bit bad_pc(input logic [31:0] a);
        longint v = longint'(a);
        return (v % 4 != 0) || (v < BASE) || (v >= TOP);
    endfunction

    task automatic model_reset();
        m_pc = 32'hBFC0_0000; m_halt = 0; m_cnt = 0;
        m_valid = 0; m_instr = NOP; m_ipc = 0; m_pc4 = 0; m_fault = 0;
    endtask

    task automatic model_step(input bit s, input bit r, input logic [31:0] t);
        if (r) begin
            m_pc = t; m_halt = 0; m_valid = 0; m_instr = NOP; m_ipc = 0; m_pc4 = 0; m_fault = 0;
        end else if (s) begin
        end else if (m_halt) begin
            m_valid = 0; m_instr = NOP; m_ipc = 0; m_pc4 = 0; m_fault = 0;
        end else begin
            m_valid = 1; m_ipc = m_pc; m_pc4 = m_pc + 4; m_cnt = m_cnt + 1;
            m_fault = bad_pc(m_pc);
            m_instr = m_fault ? NOP : rom_at(m_pc);
            if (m_fault) m_halt = 1; else m_pc = m_pc + 4;
        end
    endtask

    task automatic tick(input bit s, input bit r, input logic [31:0] t);
        stall = s; redirect = r; target = t;
        model_step(s, r, t);
        @(posedge clk); #1;
        stall = 0; redirect = 0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL reset_addr got=%h exp=bfc00000", imem_addr); end
        checks++; if (if_id_valid !== 1'b0 || if_id_fault !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", if_id_valid, if_id_fault); end
        checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", if_id_instr, NOP); end
        checks++; if (if_id_pc !== 0 || if_id_pc4 !== 0 || fetch_count !== 0) begin errors++; $display("FAIL reset_zero got=%h %h %h exp=0 0 0", if_id_pc, if_id_pc4, fetch_count); end
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            tick(0, 0, 0);
            checks++; if (imem_addr !== 32'hBFC0_0000 + 4 * i) begin errors++; $display("FAIL seq_addr%0d got=%h exp=%h", i, imem_addr, 32'hBFC0_0000 + 4 * i); end
            checks++; if (if_id_pc !== 32'hBFC0_0000 + 4 * (i - 1) || if_id_instr !== rom[i - 1] || if_id_valid !== 1'b1) begin
                errors++; $display("FAIL seq_ifid%0d got=%h %h %b exp=%h %h 1", i, if_id_pc, if_id_instr, if_id_valid, 32'hBFC0_0000 + 4 * (i - 1), rom[i - 1]);
            end
        end
        checks++; if (fetch_count !== 3) begin errors++; $display("FAIL seq_count got=%0d exp=3", fetch_count); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0);
            checks++; if (imem_addr !== 32'hBFC0_000C || if_id_pc !== 32'hBFC0_0008 || fetch_count !== 3) begin
                errors++; $display("FAIL stall_hold%0d got=%h %h %0d exp=bfc0000c bfc00008 3", i, imem_addr, if_id_pc, fetch_count);
            end
        end
        tick(0, 0, 0);
        checks++; if (imem_addr !== 32'hBFC0_0010 || if_id_pc !== 32'hBFC0_000C || if_id_instr !== rom[3] || fetch_count !== 4) begin
            errors++; $display("FAIL stall_resume got=%h %h %h %0d exp=bfc00010 bfc0000c %h 4", imem_addr, if_id_pc, if_id_instr, fetch_count, rom[3]);
        end
    endtask

    task automatic test_redirect_stall();
        tick(1, 1, 32'hBFC0_0100);
        checks++; if (imem_addr !== 32'hBFC0_0100 || if_id_valid !== 1'b0 || if_id_instr !== NOP || fetch_count !== 4) begin
            errors++; $display("FAIL redir_squash got=%h %b %h %0d exp=bfc00100 0 %h 4", imem_addr, if_id_valid, if_id_instr, fetch_count, NOP);
        end
        tick(0, 0, 0);
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'hBFC0_0100 || if_id_instr !== rom[64] || if_id_pc4 !== 32'hBFC0_0104) begin
            errors++; $display("FAIL redir_capture got=%b %h %h %h exp=1 bfc00100 %h bfc00104", if_id_valid, if_id_pc, if_id_instr, if_id_pc4, rom[64]);
        end
    endtask

    task automatic test_window_end();
        tick(0, 1, 32'hBFC0_0FF8);
        tick(0, 0, 0);
        tick(0, 0, 0);
        checks++; if (if_id_pc !== 32'hBFC0_0FFC || if_id_instr !== rom[1023] || if_id_fault !== 1'b0 || imem_addr !== 32'hBFC0_1000) begin
            errors++; $display("FAIL end_last got=%h %h %b %h exp=bfc00ffc %h 0 bfc01000", if_id_pc, if_id_instr, if_id_fault, imem_addr, rom[1023]);
        end
        tick(0, 0, 0);
        checks++; if (if_id_fault !== 1'b1 || if_id_valid !== 1'b1 || if_id_instr !== NOP || if_id_pc !== 32'hBFC0_1000 || imem_addr !== 32'hBFC0_1000) begin
            errors++; $display("FAIL end_fault got=%b %b %h %h %h exp=1 1 %h bfc01000 bfc01000", if_id_fault, if_id_valid, if_id_instr, if_id_pc, imem_addr, NOP);
        end
        checks++; if (fetch_count !== m_cnt) begin errors++; $display("FAIL end_count got=%0d exp=%0d", fetch_count, m_cnt); end
        for (int i = 0; i < 2; i++) begin
            tick(i == 1, 0, 0);
            checks++; if (if_id_valid !== 1'b0 || imem_addr !== 32'hBFC0_1000 || fetch_count !== m_cnt) begin
                errors++; $display("FAIL halt_bubble%0d got=%b %h %0d exp=0 bfc01000 %0d", i, if_id_valid, imem_addr, fetch_count, m_cnt);
            end
        end
        tick(0, 1, 32'hBFC0_0000);
        tick(0, 0, 0);
        checks++; if (if_id_valid !== 1'b1 || if_id_instr !== rom[0] || imem_addr !== 32'hBFC0_0004) begin
            errors++; $display("FAIL halt_exit got=%b %h %h exp=1 %h bfc00004", if_id_valid, if_id_instr, imem_addr, rom[0]);
        end
    endtask

    task automatic test_misaligned();
        tick(0, 1, 32'hBFC0_0002);
        tick(0, 0, 0);
        checks++; if (if_id_fault !== 1'b1 || if_id_pc !== 32'hBFC0_0002 || if_id_pc4 !== 32'hBFC0_0006 || if_id_instr !== NOP) begin
            errors++; $display("FAIL misal_fault got=%b %h %h %h exp=1 bfc00002 bfc00006 %h", if_id_fault, if_id_pc, if_id_pc4, if_id_instr, NOP);
        end
        tick(0, 0, 0);
        checks++; if (if_id_valid !== 1'b0 || imem_addr !== 32'hBFC0_0002) begin
            errors++; $display("FAIL misal_halt got=%b %h exp=0 bfc00002", if_id_valid, imem_addr);
        end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'hBFC0_0000 || if_id_valid !== 1'b0 || if_id_instr !== NOP || fetch_count !== 0 || if_id_pc !== 0) begin
            errors++; $display("FAIL async_reset got=%h %b %h %0d %h exp=bfc00000 0 %h 0 0", imem_addr, if_id_valid, if_id_instr, fetch_count, if_id_pc, NOP);
        end
        #2 rst_n = 1'b1;
        model_reset();
        tick(0, 0, 0);
        checks++; if (if_id_valid !== 1'b1 || if_id_instr !== rom[0] || imem_addr !== 32'hBFC0_0004 || fetch_count !== 1) begin
            errors++; $display("FAIL async_restart got=%b %h %h %0d exp=1 %h bfc00004 1", if_id_valid, if_id_instr, imem_addr, fetch_count, rom[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0: t = 32'hBFC0_0000 + 4 * $urandom_range(0, 1023);
                1: t = 32'hBFC0_1000 - 4 * $urandom_range(1, 3);
                2: t = 32'hBFC0_0000 + $urandom_range(0, 4095);
                3: t = $urandom;
                default: t = 32'hFFFF_FFFC;
            endcase
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, t);
            checks++;
            if ({imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc4, if_id_fault, fetch_count} !==
                {m_pc, m_valid, m_instr, m_ipc, m_pc4, m_fault, m_cnt}) begin
                errors++;
                if (bad++ < 10)
                    $display("FAIL rand%0d got=%h %b %h %h %h %b %0d exp=%h %b %h %h %h %b %0d", i,
                             imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc4, if_id_fault, fetch_count,
                             m_pc, m_valid, m_instr, m_ipc, m_pc4, m_fault, m_cnt);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        target = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_window_end();
        test_misaligned();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
